// File: rtl/p_ex_mdu_pkg.sv
// Shared encodings for the execute stage: instruction categories, local opcodes,
// EX FSM states and the compact mul/div function code used by p_mdu_iter.
package p_ex_mdu_pkg;

  localparam int OPC_W = 5;

  localparam logic [2:0] IC_NONE = 3'd0;
  localparam logic [2:0] IC_LAS  = 3'd1;
  localparam logic [2:0] IC_ARI  = 3'd2;
  localparam logic [2:0] IC_SFT  = 3'd3;
  localparam logic [2:0] IC_LGC  = 3'd4;
  localparam logic [2:0] IC_MDU  = 3'd5;

  localparam logic [OPC_W-1:0] INS_EMP    = 5'd0;
  localparam logic [OPC_W-1:0] INS_ADD    = 5'd1;
  localparam logic [OPC_W-1:0] INS_SUB    = 5'd2;
  localparam logic [OPC_W-1:0] INS_SLT    = 5'd3;
  localparam logic [OPC_W-1:0] INS_SLTU   = 5'd4;
  localparam logic [OPC_W-1:0] INS_SLL    = 5'd5;
  localparam logic [OPC_W-1:0] INS_SRL    = 5'd6;
  localparam logic [OPC_W-1:0] INS_SRA    = 5'd7;
  localparam logic [OPC_W-1:0] INS_XOR    = 5'd8;
  localparam logic [OPC_W-1:0] INS_OR     = 5'd9;
  localparam logic [OPC_W-1:0] INS_AND    = 5'd10;
  localparam logic [OPC_W-1:0] INS_LB     = 5'd11;
  localparam logic [OPC_W-1:0] INS_LH     = 5'd12;
  localparam logic [OPC_W-1:0] INS_LW     = 5'd13;
  localparam logic [OPC_W-1:0] INS_LBU    = 5'd14;
  localparam logic [OPC_W-1:0] INS_LHU    = 5'd15;
  localparam logic [OPC_W-1:0] INS_SB     = 5'd16;
  localparam logic [OPC_W-1:0] INS_SH     = 5'd17;
  localparam logic [OPC_W-1:0] INS_SW     = 5'd18;
  localparam logic [OPC_W-1:0] INS_MUL    = 5'd19;
  localparam logic [OPC_W-1:0] INS_MULH   = 5'd20;
  localparam logic [OPC_W-1:0] INS_MULHSU = 5'd21;
  localparam logic [OPC_W-1:0] INS_MULHU  = 5'd22;
  localparam logic [OPC_W-1:0] INS_DIV    = 5'd23;
  localparam logic [OPC_W-1:0] INS_DIVU   = 5'd24;
  localparam logic [OPC_W-1:0] INS_REM    = 5'd25;
  localparam logic [OPC_W-1:0] INS_REMU   = 5'd26;

  typedef enum logic [1:0] {
    EXS_IDLE = 2'd0,
    EXS_MUL  = 2'd1,
    EXS_DIV  = 2'd2,
    EXS_DONE = 2'd3
  } exs_t;

  typedef enum logic [2:0] {
    MF_MUL    = 3'd0,
    MF_MULH   = 3'd1,
    MF_MULHSU = 3'd2,
    MF_MULHU  = 3'd3,
    MF_DIV    = 3'd4,
    MF_DIVU   = 3'd5,
    MF_REM    = 3'd6,
    MF_REMU   = 3'd7
  } mfn_t;

  typedef struct packed {
    logic known;
    mfn_t fn;
  } mdu_dec_t;

  function automatic mdu_dec_t mdu_decode(input logic [OPC_W-1:0] opc);
    mdu_dec_t d;
    d.known = 1'b1;
    d.fn    = MF_MUL;
    case (opc)
      INS_MUL:    d.fn = MF_MUL;
      INS_MULH:   d.fn = MF_MULH;
      INS_MULHSU: d.fn = MF_MULHSU;
      INS_MULHU:  d.fn = MF_MULHU;
      INS_DIV:    d.fn = MF_DIV;
      INS_DIVU:   d.fn = MF_DIVU;
      INS_REM:    d.fn = MF_REM;
      INS_REMU:   d.fn = MF_REMU;
      default:    d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/p_mdu_iter.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on magnitudes.
// EX_FAST_MUL_EN: multiplies complete at start through a combinational multiplier.
module p_mdu_iter
  import p_ex_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            kill,
  input  logic            start,
  input  mfn_t            fn,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            skip,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [CW-1:0]     cnt_q;
  mfn_t              fn_q;
  logic              neg_q, rneg_q, spec_q;
  logic [XLEN-1:0]   spec_val_q, opd_q;
  logic [2*XLEN-1:0] prod_q;

  logic              is_div, op1_sgn, op2_sgn, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2, spec_val;

  always_comb begin
    is_div   = fn inside {MF_DIV, MF_DIVU, MF_REM, MF_REMU};
    op1_sgn  = fn inside {MF_MUL, MF_MULH, MF_MULHSU, MF_DIV, MF_REM};
    op2_sgn  = fn inside {MF_MUL, MF_MULH, MF_DIV, MF_REM};
    s1       = op1_sgn & op1[XLEN-1];
    s2       = op2_sgn & op2[XLEN-1];
    mag1     = neg_if(op1, s1);
    mag2     = neg_if(op2, s2);
    div_zero = is_div && (op2 == '0);
    div_ovf  = is_div && op2_sgn && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    spec_val = '0;
    if (div_zero)
      spec_val = (fn inside {MF_DIV, MF_DIVU}) ? '1 : op1;
    else if (div_ovf)
      spec_val = (fn == MF_DIV) ? op1 : '0;
    skip = div_zero | div_ovf;
`ifdef EX_FAST_MUL_EN
    skip = skip | !is_div;
`endif
  end

  // One iteration: mul adds the multiplicand into the high half when the
  // current multiplier bit is set; div shifts {rem, quo} and trial-subtracts.
  logic [XLEN:0]     msum, dsh;
  logic [XLEN+1:0]   ddiff;
  logic [2*XLEN-1:0] step;

  always_comb begin
    msum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    dsh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    ddiff = {1'b0, dsh} - {2'b00, opd_q};
    if (fn_q inside {MF_DIV, MF_DIVU, MF_REM, MF_REMU}) begin
      if (!ddiff[XLEN+1])
        step = {ddiff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
      else
        step = {dsh[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
    end else begin
      if (prod_q[0])
        step = {msum, prod_q[XLEN-1:1]};
      else
        step = {1'b0, prod_q[2*XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (en) begin
      if (kill)
        cnt_q <= '0;
      else if (start)
        cnt_q <= skip ? '0 : CW'(XLEN);
      else if (cnt_q != '0)
        cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && !kill) begin
      if (start) begin
        fn_q       <= fn;
        neg_q      <= s1 ^ s2;
        rneg_q     <= s1;
        spec_q     <= div_zero | div_ovf;
        spec_val_q <= spec_val;
        opd_q      <= is_div ? mag2 : mag1;
        prod_q     <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
`ifdef EX_FAST_MUL_EN
        if (!is_div)
          prod_q <= {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
`endif
      end else if (cnt_q != '0) begin
        prod_q <= step;
      end
    end
  end

  assign last = (cnt_q == CW'(1));

  // Sign correction of the magnitude result; special cases bypass it.
  logic [2*XLEN-1:0] wide;

  always_comb begin
    wide = neg_if_wide(prod_q, neg_q);
    case (fn_q)
      MF_MUL:                       result = wide[XLEN-1:0];
      MF_MULH, MF_MULHSU, MF_MULHU: result = wide[2*XLEN-1:XLEN];
      MF_DIV, MF_DIVU:              result = neg_if(prod_q[XLEN-1:0], neg_q);
      default:                      result = neg_if(prod_q[2*XLEN-1:XLEN], rneg_q);
    endcase
    if (spec_q)
      result = spec_val_q;
  end

endmodule

// File: rtl/p_ex_mdu.sv
// Execute stage: single-cycle ALU/shift/logic/address ops plus an iterative
// mul/div unit, registered into EX/MEM. EX_FAST_MUL_EN selects a one-shot multiplier.
module p_ex_mdu
  import p_ex_mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int OPW  = 5
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_catagory,
  input  logic [OPW-1:0]  in_opcode,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [XLEN-1:0] in_offset,
  input  logic            in_we,
  input  logic [REGW-1:0] in_w_addr,
  input  logic            mem_busy_in,
  output logic            out_valid,
  output logic            out_we,
  output logic [REGW-1:0] out_w_addr,
  output logic [XLEN-1:0] out_w_data,
  output logic [OPW-1:0]  out_opcode,
  output logic [XLEN-1:0] mem_addr,
  output logic            busy_out
);

  localparam int SHW = $clog2(XLEN);

  exs_t            state;
  logic            pend_we;
  logic [REGW-1:0] pend_addr;
  logic [OPW-1:0]  pend_op;

  logic [OPC_W-1:0] opc;
  mdu_dec_t         dec;
  logic             accept, mdu_start, single_wr, done_wr;
  logic             mdu_skip, mdu_last;
  logic [XLEN-1:0]  mdu_result, alu_data, alu_addr;
  logic [SHW-1:0]   sa;

  assign opc = OPC_W'(in_opcode);
  assign dec = mdu_decode(opc);
  assign sa  = in_op2[SHW-1:0];

  assign in_ready  = (state == EXS_IDLE) && (!out_valid || !mem_busy_in) && rdy_in
                     && !rst_in && !flush_in;
  assign accept    = in_valid && in_ready;
  assign mdu_start = accept && (in_catagory == IC_MDU) && dec.known;
  assign single_wr = accept && !mdu_start;
  assign done_wr   = (state == EXS_DONE) && (!out_valid || !mem_busy_in);
  assign busy_out  = (state != EXS_IDLE);

  always_comb begin
    alu_data = '0;
    alu_addr = '0;
    case (in_catagory)
      IC_LAS: alu_addr = in_op1 + in_offset;
      IC_ARI: begin
        case (opc)
          INS_ADD:  alu_data = in_op1 + in_op2;
          INS_SUB:  alu_data = in_op1 - in_op2;
          INS_SLT:  alu_data = {{(XLEN-1){1'b0}}, ($signed(in_op1) < $signed(in_op2))};
          INS_SLTU: alu_data = {{(XLEN-1){1'b0}}, (in_op1 < in_op2)};
          default:  alu_data = '0;
        endcase
      end
      IC_SFT: begin
        case (opc)
          INS_SLL: alu_data = in_op1 << sa;
          INS_SRL: alu_data = in_op1 >> sa;
          INS_SRA: alu_data = $signed(in_op1) >>> sa;
          default: alu_data = '0;
        endcase
      end
      IC_LGC: begin
        case (opc)
          INS_XOR: alu_data = in_op1 ^ in_op2;
          INS_OR:  alu_data = in_op1 | in_op2;
          INS_AND: alu_data = in_op1 & in_op2;
          default: alu_data = '0;
        endcase
      end
      default: ;
    endcase
  end

  p_mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu (
    .clk    (clk_in),
    .rst    (rst_in),
    .en     (rdy_in),
    .kill   (flush_in),
    .start  (mdu_start),
    .fn     (dec.fn),
    .op1    (in_op1),
    .op2    (in_op2),
    .skip   (mdu_skip),
    .last   (mdu_last),
    .result (mdu_result)
  );

  // FSM and EX/MEM output register; flush wins over accept and retirement.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= EXS_IDLE;
      out_valid  <= 1'b0;
      out_we     <= 1'b0;
      out_w_addr <= '0;
      out_w_data <= '0;
      out_opcode <= OPW'(INS_EMP);
      mem_addr   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state     <= EXS_IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          EXS_IDLE:
            if (mdu_start)
              state <= mdu_skip ? EXS_DONE : (dec.fn[2] ? EXS_DIV : EXS_MUL);
          EXS_MUL, EXS_DIV:
            if (mdu_last) state <= EXS_DONE;
          EXS_DONE:
            if (done_wr) state <= EXS_IDLE;
          default: state <= EXS_IDLE;
        endcase
        if (mdu_start) begin
          pend_we   <= in_we;
          pend_addr <= in_w_addr;
          pend_op   <= in_opcode;
        end
        if (single_wr) begin
          out_valid  <= 1'b1;
          out_we     <= in_we;
          out_w_addr <= in_w_addr;
          out_w_data <= alu_data;
          out_opcode <= in_opcode;
          mem_addr   <= alu_addr;
        end else if (done_wr) begin
          out_valid  <= 1'b1;
          out_we     <= pend_we;
          out_w_addr <= pend_addr;
          out_w_data <= mdu_result;
          out_opcode <= pend_op;
          mem_addr   <= '0;
        end else if (out_valid && !mem_busy_in) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/p_ex_mdu.md
# p_ex_mdu

Parametrised execute stage with an integrated multiply/divide unit. It replaces the purely combinational EX stage between ID/EX and EX/MEM. ALU, shift, logic and load/store address operations complete in one cycle. RV32M multiply/divide operations run on an iterative datapath with a valid/ready handshake, and results are registered into the EX/MEM boundary.

## Interface
- `XLEN`, 32: operand and result width.
- `REGW`, 5: register-address width.
- `OPW`, 5: local opcode width.
- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global enable; when low, all state and outputs hold.
- `flush_in` in 1: kill in-flight and pending op (branch mispredict).
- `in_valid` in 1: ID/EX presents an op.
- `in_ready` out 1: EX accepts the op this cycle.
- `in_catagory` in 3: instruction category (`IC_*`).
- `in_opcode` in OPW: local opcode (`INS_*`).
- `in_op1`, `in_op2`, `in_offset` in XLEN: operands and load/store offset.
- `in_we` in 1: register write enable.
- `in_w_addr` in REGW: register write address.
- `mem_busy_in` in 1: downstream stall; EX/MEM outputs must hold.
- `out_valid` out 1: EX/MEM register holds a valid result.
- `out_we` out 1: register write enable.
- `out_w_addr` out REGW: register write address.
- `out_w_data` out XLEN: result data.
- `out_opcode` out OPW: opcode forwarded to MEM.
- `mem_addr` out XLEN: load/store effective address.
- `busy_out` out 1: high while the MDU is iterating (hazard/forwarding stall).

## Operation
- States: IDLE, MUL, DIV, DONE.
- Ops are accepted on `in_valid && in_ready`.
- `in_ready` = (state==IDLE) && (!out_valid || !mem_busy_in) && rdy_in.
- Single-cycle categories write the output register at the accept edge and stay in IDLE. Results are identical to the prior stage:
  - `IC_LAS`: `mem_addr` = op1+offset; `out_w_data` = 0.
  - `IC_ARI`: add/sub/slt/sltu.
  - `IC_SFT`: shift amount = op2[log2(XLEN)-1:0].
  - `IC_LGC`: xor/or/and.
  - `mem_addr` = 0 for all non-LAS ops.
- `IC_MDU` latches operands and moves to MUL or DIV with an iteration counter of XLEN.
  - MUL: shift-add on magnitudes.
    - mul returns the low XLEN bits.
    - mulh, mulhsu, mulhu return the high XLEN bits of the 2·XLEN-bit product, sign-corrected according to operand signedness.
  - DIV: restoring, one quotient bit per cycle on magnitudes. Signs are fixed in DONE.
    - Quotient sign = sign(op1) XOR sign(op2).
    - Remainder takes the sign of op1.
  - Counter reaches 0 → DONE. DONE writes the output register and returns to IDLE.
- Division special cases skip iteration (IDLE → DONE):
  - Divisor 0: quotient = all ones; remainder = op1.
  - Signed overflow (op1 = most-negative, op2 = −1): quotient = op1; remainder = 0.
- Unknown opcode within a category: `out_w_data` = 0; `we` passes through unchanged.
- Output register:
  - Loaded only on an accept (single-cycle op) or in DONE.
  - Holds while `mem_busy_in`.
  - Clears `out_valid` when consumed with no new result.
- `flush_in` (priority over accept):
  - Returns to IDLE and clears `out_valid`.
  - The MDU result is discarded.
  - An op offered in the same cycle is not accepted.
- `busy_out` = (state != IDLE).
- `rdy_in` low freezes state, counter and outputs; `in_ready` = 0.

## Timing
- Reset, synchronous:
  - State IDLE, counter 0.
  - `out_valid`, `out_we`, `busy_out` = 0.
  - `out_w_addr`, `out_w_data`, `mem_addr` = 0.
  - `out_opcode` = `INS_EMP`.
  - `in_ready` = 0 during reset, 1 from the first cycle after.
- Reset mid-iteration aborts with no output.
- Single-cycle op: `out_valid` rises 1 cycle after accept.
- MUL/DIV: `out_valid` rises XLEN+2 cycles after accept (1 entry + XLEN iterations + DONE). Special-case divide: 2 cycles.
- DONE while `mem_busy_in` and `out_valid` are high: DONE holds until the register frees, then writes.
- Back-to-back single-cycle ops sustain 1 op/cycle.

## Configuration
- `EX_FAST_MUL_EN` defined:
  - Multiplies use a single-cycle XLEN×XLEN combinational multiplier.
  - Path is IDLE → DONE; latency 2 cycles.
  - Divides are unchanged.
- `EX_FAST_MUL_EN` undefined: iterative multiplier, XLEN+2 cycle latency.

## Structure
- Shared `defines.v` gains:
  - `IC_MDU`.
  - `INS_MUL`, `INS_MULH`, `INS_MULHSU`, `INS_MULHU`, `INS_DIV`, `INS_DIVU`, `INS_REM`, `INS_REMU`.
  - State encodings `EXS_IDLE`, `EXS_MUL`, `EXS_DIV`, `EXS_DONE`.
- Existing `IC_*`/`INS_*` are reused unchanged.
- One sub-module, `p_mdu_iter`: the iterative mul/div datapath (operand latch, counter, sign fix, special cases) with start/done handshake. Top-level holds the FSM, single-cycle ALU and output register.

## Test plan
- Back-to-back ADD 5+7 then SUB 3−5 → `out_w_data` 12 then 0xFFFFFFFE on consecutive cycles; `in_ready` stays 1.
- MULH 0x80000000 × 0x80000000 → 0x40000000 after 34 cycles; `busy_out` high for the iteration; `in_ready` low.
- DIV −7/2 → quotient 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF; REM 0x80000000/−1 → 0 in 2 cycles.
- `mem_busy_in` held high for 3 cycles with a result pending → outputs stable; new ADD not accepted until release.
- `flush_in` at iteration 10 of a DIVU → `out_valid` never rises for it; next ADD accepted the following cycle.
- Reset asserted mid-MUL → all outputs at reset values next cycle; with `EX_FAST_MUL_EN`, MUL 6×7 → 42 in 2 cycles.
